// File: rtl/cp0_unit_if.sv
// Pipeline-side bundle for cp0_unit: MTC0/MFC0 access, exception/ERET events,
// interrupt lines and register-content taps.
interface cp0_unit_if #(
  parameter int unsigned HW_INT_N = 6
);
  logic                we_i;
  logic [4:0]          waddr_i;
  logic [4:0]          raddr_i;
  logic [31:0]         data_i;
  logic [HW_INT_N-1:0] int_i;
  logic                exc_valid_i;
  logic [4:0]          exc_code_i;
  logic                exc_eret_i;
  logic [31:0]         exc_pc_i;
  logic                exc_delayslot_i;
  logic [31:0]         exc_badvaddr_i;
  logic [31:0]         data_o;
  logic [31:0]         count_o;
  logic [31:0]         compare_o;
  logic [31:0]         status_o;
  logic [31:0]         cause_o;
  logic [31:0]         epc_o;
  logic [31:0]         badvaddr_o;
  logic                timer_int_o;
  logic                int_pending_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i,
    output exc_valid_i, exc_code_i, exc_eret_i, exc_pc_i, exc_delayslot_i, exc_badvaddr_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
    input  timer_int_o, int_pending_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i,
    input  exc_valid_i, exc_code_i, exc_eret_i, exc_pc_i, exc_delayslot_i, exc_badvaddr_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
    output timer_int_o, int_pending_o
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file for tinyMIPS: Count/Compare timer with prescaler,
// Status/Cause/EPC/BadVAddr exception state and a registered interrupt request.
module cp0_unit #(
  parameter int unsigned HW_INT_N     = 6,
  parameter int unsigned COUNT_DIV    = 1,
  parameter int unsigned TIMER_LINE   = 5,
  parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  logic       clk,
  input  logic       rst_n,
  cp0_unit_if.slave  bus
);

  localparam int unsigned PS_W        = 8;
  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  REG_PRID     = 5'd15;
  localparam logic [4:0]  REG_CONFIG   = 5'd16;
  localparam logic [31:0] STATUS_MASK  = 32'h1000_FF03;
  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;

  logic [PS_W-1:0] r_presc;
  logic [31:0]     r_count;
  logic [31:0]     r_compare;
  logic [31:0]     r_status;
  logic [31:0]     r_epc;
  logic [31:0]     r_badvaddr;
  logic            r_timer;
  logic            r_ti;
  logic            r_bd;
  logic [5:0]      r_ip_hw;
  logic [1:0]      r_ip_sw;
  logic [4:0]      r_exccode;
  logic            r_pend;

  logic            w_wr_count;
  logic            w_wr_compare;
  logic            w_wr_status;
  logic            w_wr_cause;
  logic            w_wr_epc;
  logic            w_tick;
  logic            w_timer_set;
  logic            w_old_exl;
  logic            w_addr_exc;
  logic [5:0]      w_ip_hw;
  logic [31:0]     w_status_nxt;
  logic [31:0]     w_cause;
  logic [31:0]     w_rdata;

  assign w_wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign w_wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
  assign w_wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
  assign w_wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
  assign w_wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);

  assign w_tick      = (r_presc == PS_W'(COUNT_DIV - 1));
  assign w_timer_set = (r_compare != 32'd0) && (r_count == r_compare);
  assign w_old_exl   = r_status[1];
  assign w_addr_exc  = (bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5);
  assign w_ip_hw     = 6'(bus.int_i) | (6'(r_timer) << TIMER_LINE);
  assign w_cause     = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};

  // Status: MTC0 masked write, then exception/ERET override of EXL (exception wins)
  always_comb begin
    w_status_nxt = r_status;
    if (w_wr_status) begin
      w_status_nxt = bus.data_i & STATUS_MASK;
    end
    if (bus.exc_valid_i) begin
      w_status_nxt[1] = 1'b1;
    end else if (bus.exc_eret_i) begin
      w_status_nxt[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_presc    <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_status   <= STATUS_RST;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_timer    <= 1'b0;
      r_ti       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_exccode  <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= bus.data_i;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PS_W'(1);
      end

      if (w_wr_compare) begin
        r_compare <= bus.data_i;
        r_timer   <= 1'b0;
      end else if (w_timer_set) begin
        r_timer <= 1'b1;
      end

      // Cause IP/TI are sampled every cycle, one cycle behind their sources
      r_ti    <= r_timer;
      r_ip_hw <= w_ip_hw;
      if (w_wr_cause) begin
        r_ip_sw <= bus.data_i[9:8];
      end

      r_status <= w_status_nxt;

      if (bus.exc_valid_i) begin
        r_exccode <= bus.exc_code_i;
        if (!w_old_exl) begin
          r_bd  <= bus.exc_delayslot_i;
          r_epc <= bus.exc_delayslot_i ? 32'(bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
        end
        if (w_addr_exc) begin
          r_badvaddr <= bus.exc_badvaddr_i;
        end
      end else if (w_wr_epc) begin
        r_epc <= bus.data_i;
      end

      r_pend <= r_status[0] & ~r_status[1] & (|(w_cause[15:8] & r_status[15:8]));
    end
  end

  // MFC0 read mux; forced to zero while in reset
  always_comb begin
    w_rdata = 32'd0;
    if (!rst_n) begin
      case (bus.raddr_i)
        REG_BADVADDR: w_rdata = r_badvaddr;
        REG_COUNT:    w_rdata = r_count;
        REG_COMPARE:  w_rdata = r_compare;
        REG_STATUS:   w_rdata = r_status;
        REG_CAUSE:    w_rdata = w_cause;
        REG_EPC:      w_rdata = r_epc;
        REG_PRID:     w_rdata = PRID_VALUE;
        REG_CONFIG:   w_rdata = CONFIG_VALUE;
        default:      w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_o        = w_rdata;
  assign bus.count_o       = r_count;
  assign bus.compare_o     = r_compare;
  assign bus.status_o      = r_status;
  assign bus.cause_o       = w_cause;
  assign bus.epc_o         = r_epc;
  assign bus.badvaddr_o    = r_badvaddr;
  assign bus.timer_int_o   = r_timer;
  assign bus.int_pending_o = r_pend;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed scoreboard bench for cp0_unit: one COUNT_DIV=1 and one COUNT_DIV=4
// instance share the same stimulus.
module tb_cp0_unit;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [4:0]  raddr;
  logic [31:0] wdata;
  logic [5:0]  irq;
  logic        exc_v;
  logic [4:0]  exc_code;
  logic        eret;
  logic [31:0] exc_pc;
  logic        exc_ds;
  logic [31:0] exc_bva;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec;
  int unsigned n_bad;

  cp0_unit_if #(.HW_INT_N(6)) bus1 ();
  cp0_unit_if #(.HW_INT_N(6)) bus4 ();

  assign bus1.we_i = we;             assign bus4.we_i = we;
  assign bus1.waddr_i = waddr;       assign bus4.waddr_i = waddr;
  assign bus1.raddr_i = raddr;       assign bus4.raddr_i = raddr;
  assign bus1.data_i = wdata;        assign bus4.data_i = wdata;
  assign bus1.int_i = irq;           assign bus4.int_i = irq;
  assign bus1.exc_valid_i = exc_v;   assign bus4.exc_valid_i = exc_v;
  assign bus1.exc_code_i = exc_code; assign bus4.exc_code_i = exc_code;
  assign bus1.exc_eret_i = eret;     assign bus4.exc_eret_i = eret;
  assign bus1.exc_pc_i = exc_pc;     assign bus4.exc_pc_i = exc_pc;
  assign bus1.exc_delayslot_i = exc_ds;  assign bus4.exc_delayslot_i = exc_ds;
  assign bus1.exc_badvaddr_i = exc_bva;  assign bus4.exc_badvaddr_i = exc_bva;

  cp0_unit #(.COUNT_DIV(1)) u_div1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cp0_unit #(.COUNT_DIV(4)) u_div4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bva, input logic with_eret);
    exc_v = 1'b1; exc_code = code; exc_pc = pc; exc_ds = ds; exc_bva = bva; eret = with_eret;
    step();
    exc_v = 1'b0; eret = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b1; we = 1'b0; waddr = '0; raddr = 5'd12; wdata = '0; irq = '0;
    exc_v = 1'b0; exc_code = '0; eret = 1'b0; exc_pc = '0; exc_ds = 1'b0; exc_bva = '0;
    step(); step();

    // Reset state
    push("rst_count", 32'd0);            check(bus1.count_o);
    push("rst_status", 32'h1000_0000);   check(bus1.status_o);
    push("rst_cause", 32'd0);            check(bus1.cause_o);
    push("rst_timer", 32'd0);            check(32'(bus1.timer_int_o));
    push("rst_pend", 32'd0);             check(32'(bus1.int_pending_o));
    push("rst_rdata", 32'd0);            check(bus1.data_o);

    // Prescaler with COUNT_DIV=4
    rst_n = 1'b0;
    push("div4_c1", 32'd0); step(); check(bus4.count_o);
    push("div4_c2", 32'd0); step(); check(bus4.count_o);
    push("div4_c3", 32'd0); step(); check(bus4.count_o);
    push("div4_c4", 32'd1); push("div1_c4", 32'd4); step();
    check(bus4.count_o); check(bus1.count_o);

    push("div4_load", 32'hFFFF_FFFF); mtc0(5'd9, 32'hFFFF_FFFF); check(bus4.count_o);
    step(); step();
    push("div4_hold", 32'hFFFF_FFFF); step(); check(bus4.count_o);
    push("div4_wrap", 32'd0); push("div1_wrap", 32'd3); step();
    check(bus4.count_o); check(bus1.count_o);

    // Timer on COUNT_DIV=1
    mtc0(5'd11, 32'd10);
    push("cmp_val", 32'd10); check(bus1.compare_o);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 10; i++) step();
    push("tmr_cnt10", 32'd10); push("tmr_pre", 32'd0);
    check(bus1.count_o); check(32'(bus1.timer_int_o));
    push("tmr_set", 32'd1); step(); check(32'(bus1.timer_int_o));
    push("tmr_cause", 32'h4000_8000); push("tmr_sticky", 32'd1); step();
    check(bus1.cause_o); check(32'(bus1.timer_int_o));
    push("tmr_clr", 32'd0); mtc0(5'd11, 32'd0); check(32'(bus1.timer_int_o));
    push("tmr_cause_clr", 32'd0); step(); check(bus1.cause_o);

    // Hardware interrupt to int_pending_o
    push("st_401", 32'h0000_0401); mtc0(5'd12, 32'h0000_0401); check(bus1.status_o);
    irq = 6'b000001;
    push("irq_pend0", 32'd0); push("irq_cause", 32'h0000_0400); step();
    check(32'(bus1.int_pending_o)); check(bus1.cause_o);
    push("irq_pend1", 32'd1); step(); check(32'(bus1.int_pending_o));
    push("exl_status", 32'h0000_0403); mtc0(5'd12, 32'h0000_0403); check(bus1.status_o);
    push("exl_pend0", 32'd0); step(); check(32'(bus1.int_pending_o));

    // Exceptions
    irq = '0;
    mtc0(5'd12, 32'h1000_0000);
    push("exc1_epc", 32'h0000_00FC); push("exc1_cause", 32'h8000_0010);
    push("exc1_bva", 32'hDEAD_BEEF); push("exc1_status", 32'h1000_0002);
    exc(5'd4, 32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check(bus1.epc_o); check(bus1.cause_o); check(bus1.badvaddr_o); check(bus1.status_o);
    push("exc2_epc", 32'h0000_00FC); push("exc2_cause", 32'h8000_0030); push("exc2_bva", 32'hDEAD_BEEF);
    exc(5'd12, 32'h200, 1'b0, 32'h1234_5678, 1'b0);
    check(bus1.epc_o); check(bus1.cause_o); check(bus1.badvaddr_o);
    push("eret_status", 32'h1000_0000);
    eret = 1'b1; step(); eret = 1'b0; check(bus1.status_o);
    push("both_status", 32'h1000_0002); push("both_epc", 32'h0000_0300);
    exc(5'd0, 32'h300, 1'b0, 32'd0, 1'b1);
    check(bus1.status_o); check(bus1.epc_o);
    push("eret2_status", 32'h1000_0000);
    eret = 1'b1; step(); eret = 1'b0; check(bus1.status_o);

    // MTC0 Status together with an address-error exception
    we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FF00;
    push("mix_status", 32'h1000_FF02); push("mix_bva", 32'hCAFE_0000); push("mix_epc", 32'h0000_0400);
    exc(5'd5, 32'h400, 1'b0, 32'hCAFE_0000, 1'b0);
    we = 1'b0;
    check(bus1.status_o); check(bus1.badvaddr_o); check(bus1.epc_o);

    // Write masks and read mux
    mtc0(5'd12, 32'hFFFF_FFFF);
    raddr = 5'd12; #1; push("rd_status", 32'h1000_FF03); check(bus1.data_o);
    raddr = 5'd3;  #1; push("rd_unmapped", 32'd0); check(bus1.data_o);
    mtc0(5'd15, 32'd0);
    raddr = 5'd15; #1; push("rd_prid", 32'h004C_0102); check(bus1.data_o);
    raddr = 5'd16; #1; push("rd_config", 32'h0000_8000); check(bus1.data_o);
    mtc0(5'd8, 32'h5555_5555);
    raddr = 5'd8;  #1; push("rd_bva_ro", 32'hCAFE_0000); check(bus1.data_o);
    mtc0(5'd13, 32'hFFFF_FFFF);
    raddr = 5'd13; #1; push("rd_cause", 32'h0000_0314); check(bus1.data_o);
    raddr = 5'd14; #1; push("rd_epc", 32'h0000_0400); check(bus1.data_o);

    // Reset mid-operation
    rst_n = 1'b1; step();
    push("mrst_status", 32'h1000_0000); push("mrst_epc", 32'd0);
    push("mrst_bva", 32'd0); push("mrst_cause", 32'd0); push("mrst_count", 32'd0);
    check(bus1.status_o); check(bus1.epc_o); check(bus1.badvaddr_o);
    check(bus1.cause_o); check(bus4.count_o);
    rst_n = 1'b0;
    push("post_rst_c", 32'd1); step(); check(bus1.count_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 block for the tinyMIPS pipeline, successor to the fixed CP0 register set. It holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config and adds a Count prescaler, a configurable hardware-interrupt width and timer line, write masks, BadVAddr capture and a registered interrupt-pending output. It sits beside the MEM/WB stage: it takes MTC0 writes and committed exception/ERET events, and serves MFC0 reads.

## Interface
- HW_INT_N, 6: number of external interrupt lines, 1..6, mapped to Cause[10 +: HW_INT_N].
- COUNT_DIV, 1: Count increments once every COUNT_DIV cycles, 1..256.
- TIMER_LINE, 5: IP index (0..5) that the timer ORs into Cause[10+TIMER_LINE].
- PRID_VALUE, 32'h004C0102: constant PRId.
- CONFIG_VALUE, 32'h00008000: constant Config.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-high reset; despite the name, 1 = reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  write register number.
- raddr_i  in  5  read register number.
- data_i  in  32  write data.
- int_i  in  HW_INT_N  level interrupt requests.
- exc_valid_i  in  1  committed exception this cycle.
- exc_code_i  in  5  ExcCode of that exception.
- exc_eret_i  in  1  committed ERET.
- exc_pc_i  in  32  PC of the excepting instruction.
- exc_delayslot_i  in  1  excepting instruction is in a delay slot.
- exc_badvaddr_i  in  32  faulting address, AdEL/AdES only.
- data_o  out  32  combinational read data.
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  register contents.
- timer_int_o  out  1  sticky timer request.
- int_pending_o  out  1  registered interrupt-taken request.

## Operation
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
- Reset values: Count 0, Compare 0, Status 32'h1000_0000, Cause 0, EPC 0, BadVAddr 0, timer_int_o 0, int_pending_o 0, prescaler 0.
- Prescaler: counts 0..COUNT_DIV-1. A tick occurs when it equals COUNT_DIV-1; it then wraps to 0. Count increments on each tick and wraps 32'hFFFF_FFFF -> 0.
- MTC0 Count: loads data_i and clears the prescaler.
- Timer: the timer sets when Compare != 0 and Count == Compare, both registered values. It stays set until an MTC0 to Compare, which also loads Compare. If a clear and a set occur in the same cycle, the clear wins.
- Status write mask: bits 28, 15:8, 1 (EXL) and 0 (IE). All other bits read 0.
- Cause fields:
  - Bit 31 is BD.
  - Bit 30 is TI, which mirrors the timer.
  - Bits 15:10 are int_i zero-extended to 6 bits, ORed with (timer << TIMER_LINE). They are refreshed every cycle.
  - Bits 9:8 are software-writable.
  - Bits 6:2 are ExcCode.
  - All other bits read 0.
- EPC: fully writable. BadVAddr: read-only to MTC0. Writes to PRId, Config or unmapped numbers are ignored.
- Exception (exc_valid_i = 1):
  - ExcCode <= exc_code_i and EXL <= 1.
  - If the old EXL is 0: EPC <= exc_pc_i - 4 and BD <= 1 when exc_delayslot_i = 1; otherwise EPC <= exc_pc_i and BD <= 0.
  - If the old EXL is 1: EPC and BD are unchanged.
  - If exc_code_i is 4 or 5: BadVAddr <= exc_badvaddr_i.
- ERET (exc_eret_i = 1, no exception): EXL <= 0.
- If exc_valid_i and exc_eret_i are both 1, the exception wins and ERET is ignored.
- MTC0 in the same cycle as an exception: exception-driven fields (EXL, ExcCode, EPC, BD, BadVAddr) take the exception value. The remaining written bits still update.
- int_pending_o is registered as: IE & ~EXL & |(Cause[15:8] & Status[15:8]), computed from current register values.
- Read: data_o is a combinational mux on raddr_i. Unmapped numbers return 0. While rst_n = 1, data_o = 0. There is no write-to-read bypass.

## Timing
- All register updates take effect at the rising edge after the request, so values are visible one cycle later.
- A Count/Compare match at edge t gives timer_int_o = 1 after t. Cause[15+]/TI follow after t+1, and int_pending_o after t+2.
- An int_i change is visible in Cause one cycle later and in int_pending_o two cycles later.
- Reset asserted mid-operation restores every reset value at the next edge, including the prescaler and the timer.
- With COUNT_DIV = 1, Count increments every cycle.

## Test plan
- COUNT_DIV = 4, reset released: Count = 0,0,0,1 after 1..4 cycles. MTC0 Count = 32'hFFFF_FFFF, then 4 cycles -> Count = 0.
- Compare = 10, COUNT_DIV = 1, Count = 0: timer_int_o rises one cycle after Count = 10. It stays high, and Cause bit 15 = 1 with TIMER_LINE = 5. MTC0 Compare = 0 -> timer_int_o = 0 next cycle.
- Status = 32'h0000_0401, int_i = 6'b000001: int_pending_o = 1 two cycles later. Set EXL -> int_pending_o = 0.
- Exception code 4, pc 32'h100, delay slot = 1, EXL = 0: EPC = 32'hFC, BD = 1, ExcCode = 4, BadVAddr = exc_badvaddr_i. A second exception with pc 32'h200 -> EPC stays 32'hFC.
- Same-cycle exception and ERET -> EXL = 1. ERET alone -> EXL = 0.
- MTC0 Status = 32'hFFFF_FFFF -> Status reads 32'h1000_FF03. Read of raddr 3 -> 0.
